// File: rtl/mdu_hilo_writer_pkg.sv
// Shared encodings and widths for the multiply/divide unit feeding the HI/LO write port.
package mdu_hilo_writer_pkg;

  localparam int MDU_DATA_WIDTH = 32;
  localparam int MDU_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_STATE_IDLE = 2'b00,
    MDU_STATE_RUN  = 2'b01,
    MDU_STATE_FIN  = 2'b10
  } mdu_state_e;

  function automatic logic mdu_op_signed(input mdu_op_e op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_hilo_writer_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor when it fits.
module mdu_div_step
  import mdu_hilo_writer_pkg::*;
#(
  parameter int W = MDU_DATA_WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = shifted >= {1'b0, div_i};
  // When the divisor fits the true difference is below 2^W, so W-bit wraparound is exact.
  assign rem_o   = q_o ? (shifted[W-1:0] - div_i) : shifted[W-1:0];

endmodule

// File: rtl/mdu_hilo_writer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a one-cycle HI/LO write.
// Define MDU_ITER_MUL_EN to run multiplies through the shared shift-add RUN path.
module mdu_hilo_writer
  import mdu_hilo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH,
  parameter int CNT_WIDTH  = MDU_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  write_en_o,
  output logic [DATA_WIDTH-1:0] hi_out_o,
  output logic [DATA_WIDTH-1:0] lo_out_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  // state | meaning
  // IDLE  | waiting for start; multiply result registered here in the default build
  // RUN   | one divide (or shift-add multiply) iteration per cycle
  // FIN   | result stable, write strobe unless flushed
  mdu_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic res_neg_q, res_neg_d, rem_neg_q, rem_neg_d, dbz_q, dbz_d;
  logic [W-1:0] a_raw_q, a_raw_d, b_mag_q, b_mag_d;
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;

  mdu_op_e op;
  logic is_div, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag, step_rem, quo_nx;
  logic step_q;

  assign op     = mdu_op_e'(op_i);
  assign is_div = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  assign a_neg  = mdu_op_signed(op) && operand_a_i[W-1];
  assign b_neg  = mdu_op_signed(op) && operand_b_i[W-1];
  assign a_mag  = a_neg ? -operand_a_i : operand_a_i;
  assign b_mag  = b_neg ? -operand_b_i : operand_b_i;

  mdu_div_step #(.W(W)) u_div_step (
    .rem_i (rem_q),
    .div_i (b_mag_q),
    .bit_i (quo_q[W-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quo_nx = {quo_q[W-2:0], step_q};

`ifdef MDU_ITER_MUL_EN
  logic is_mul_q, is_mul_d;
  logic [W:0] mul_sum;
  logic [W-1:0] mul_hi, mul_lo;

  // Accumulator {rem_q, quo_q} holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_mag_q} : '0);
  assign mul_hi  = mul_sum[W:1];
  assign mul_lo  = {mul_sum[0], quo_q[W-1:1]};
`else
  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    a_raw_d   = a_raw_q;
    b_mag_d   = b_mag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MDU_ITER_MUL_EN
    is_mul_d  = is_mul_q;
`endif
    unique case (state_q)
      MDU_STATE_IDLE: begin
        if (start_i && !flush_i) begin
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dbz_d     = is_div && (operand_b_i == '0);
          a_raw_d   = operand_a_i;
          b_mag_d   = b_mag;
          rem_d     = '0;
          quo_d     = a_mag;
          cnt_d     = '0;
`ifdef MDU_ITER_MUL_EN
          is_mul_d  = !is_div;
          state_d   = MDU_STATE_RUN;
`else
          if (is_div) begin
            state_d = MDU_STATE_RUN;
          end else begin
            {hi_d, lo_d} = (a_neg ^ b_neg) ? -prod : prod;
            state_d      = MDU_STATE_FIN;
          end
`endif
        end
      end
      MDU_STATE_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_ITER_MUL_EN
        if (is_mul_q) begin
          rem_d = mul_hi;
          quo_d = mul_lo;
          if (cnt_q == LAST_ITER) begin
            {hi_d, lo_d} = res_neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
            state_d      = MDU_STATE_FIN;
          end
        end else
`endif
        begin
          rem_d = step_rem;
          quo_d = quo_nx;
          if (cnt_q == LAST_ITER) begin
            state_d = MDU_STATE_FIN;
            if (dbz_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_neg_q ? -step_rem : step_rem;
              lo_d = res_neg_q ? -quo_nx : quo_nx;
            end
          end
        end
      end
      MDU_STATE_FIN: state_d = MDU_STATE_IDLE;
      default:       state_d = MDU_STATE_IDLE;
    endcase
    if (flush_i) state_d = MDU_STATE_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= MDU_STATE_IDLE;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_raw_q   <= '0;
      b_mag_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_ITER_MUL_EN
      is_mul_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      a_raw_q   <= a_raw_d;
      b_mag_q   <= b_mag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_ITER_MUL_EN
      is_mul_q  <= is_mul_d;
`endif
    end
  end

  assign busy_o     = (state_q != MDU_STATE_IDLE);
  assign write_en_o = (state_q == MDU_STATE_FIN) && !flush_i;
  assign hi_out_o   = hi_q;
  assign lo_out_o   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// Self-checking bench for mdu_hilo_writer: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_mdu_hilo_writer;

  localparam int W = 32;
`ifdef MDU_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int DIV_LAT = 33;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, we;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_hilo_writer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .operand_a_i (a),
    .operand_b_i (b),
    .flush_i     (flush),
    .busy_o      (busy),
    .write_en_o  (we),
    .hi_out_o    (hi),
    .lo_out_o    (lo)
  );

  // {HI, LO} from plain integer arithmetic; SV division truncates toward zero like MIPS.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_vec += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    if (we !== 1'b0)   begin n_err++; $display("FAIL reset_we got %b want 0", we); end
    if (hi !== '0)     begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== '0)     begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle lat+1 (idle again).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, y, input bit noise);
    logic [63:0] exp;
    int lat;
    exp = ref_result(o, x, y);
    lat = o[1] ? DIV_LAT : MUL_LAT;
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      n_vec += 2;
      if (busy !== (c <= lat)) begin
        n_err++; $display("FAIL busy op=%0d cyc=%0d got %b want %b", o, c, busy, c <= lat);
      end
      if (we !== (c == lat)) begin
        n_err++; $display("FAIL write_en op=%0d cyc=%0d got %b want %b", o, c, we, c == lat);
      end
      if (c >= lat) begin
        n_vec += 2;
        if (hi !== exp[63:32]) begin
          n_err++; $display("FAIL hi op=%0d a=%h b=%h cyc=%0d got %h want %h", o, x, y, c, hi, exp[63:32]);
        end
        if (lo !== exp[31:0]) begin
          n_err++; $display("FAIL lo op=%0d a=%h b=%h cyc=%0d got %h want %h", o, x, y, c, lo, exp[31:0]);
        end
      end
      if (noise && c <= lat && (c == 5 || c == 20 || $urandom_range(0, 3) == 0)) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_flush_run();
    start = 1'b1; op = 2'b10; a = $urandom; b = 32'($urandom_range(1, 1000));
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (c == 10);
      n_vec += 2;
      if (we !== 1'b0) begin n_err++; $display("FAIL flush_run_we cyc=%0d got %b want 0", c, we); end
      if (busy !== (c <= 10)) begin
        n_err++; $display("FAIL flush_run_busy cyc=%0d got %b want %b", c, busy, c <= 10);
      end
    end
    flush = 1'b0;
    run_op(2'b11, 32'd10, 32'd3, 1'b0);
  endtask

  task automatic test_flush_idle();
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_vec += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    if (we !== 1'b0)   begin n_err++; $display("FAIL flush_idle_we got %b want 0", we); end
  endtask

  task automatic test_flush_fin();
    start = 1'b1; op = 2'b11; a = $urandom; b = 32'($urandom_range(1, 99));
    for (int c = 1; c <= DIV_LAT; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    n_vec += 2;
    if (busy !== 1'b1) begin n_err++; $display("FAIL flush_fin_busy got %b want 1", busy); end
    if (we !== 1'b0)   begin n_err++; $display("FAIL flush_fin_we got %b want 0", we); end
    @(negedge clk);
    flush = 1'b0;
    n_vec += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL flush_fin_after_busy got %b want 0", busy); end
    if (we !== 1'b0)   begin n_err++; $display("FAIL flush_fin_after_we got %b want 0", we); end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 2'b10; a = $urandom; b = 32'($urandom_range(1, 50));
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_vec += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    if (we !== 1'b0)   begin n_err++; $display("FAIL rst_mid_we got %b want 0", we); end
    if (hi !== '0)     begin n_err++; $display("FAIL rst_mid_hi got %h want 0", hi); end
    if (lo !== '0)     begin n_err++; $display("FAIL rst_mid_lo got %h want 0", lo); end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_vec++;
      if (we !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rst_mid_quiet cyc=%0d got we=%b busy=%b want 0 0", c, we, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_run();
    test_flush_idle();
    test_flush_fin();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
